// File: rtl/fir_filter_dat_if.sv
// Sample bus for the FIR smoothing stage: one unsigned sample in and one
// full-precision filtered result out, every clock.
interface fir_filter_dat_if #(
  parameter int DW = 8,
  parameter int OW = 20
);
  logic [DW-1:0] input_sample;
  logic [OW-1:0] output_sample;

  // Sample source / result sink side
  modport master (output input_sample, input output_sample);
  // Filter side
  modport slave  (input input_sample, output output_sample);
endinterface

// File: rtl/fir_filter_dat.sv
// 16-tap direct-form FIR low-pass with fixed symmetric coefficients.
// Free-running: one sample captured and one result registered per clock.
// The result for edge n+1 is the weighted sum of the delay line as it stood
// before that edge, so a sample enters the output one edge after capture.
module fir_filter_dat #(
  parameter int NTAPS = 16,
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int OW    = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  fir_filter_dat_if.slave bus
);

  localparam int PW = DW + CW;

  // Coefficient table is sized for the 16-tap low-pass response.
  localparam logic [NTAPS-1:0][CW-1:0] COEF = {
    8'd1,  8'd3,  8'd7,  8'd13, 8'd20, 8'd27, 8'd32, 8'd35,
    8'd35, 8'd32, 8'd27, 8'd20, 8'd13, 8'd7,  8'd3,  8'd1
  };

  logic [NTAPS-1:0][DW-1:0] r_x;
  logic [NTAPS-1:0][PW-1:0] w_prod;
  logic [OW-1:0]            w_sum;
  logic [OW-1:0]            r_out;

  // One product per tap; widths give exact 16-bit unsigned products.
  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    assign w_prod[k] = r_x[k] * COEF[k];
  end

  // Full-precision accumulation of all tap products (max 70380, fits OW).
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NTAPS; k++)
      w_sum = w_sum + OW'(w_prod[k]);
  end

  // Delay line shift and output register; reset clears the whole history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_out <= '0;
    end else begin
      r_x   <= {r_x[NTAPS-2:0], bus.input_sample};
      r_out <= w_sum;
    end
  end

  assign bus.output_sample = r_out;

endmodule

// File: tb/tb_fir_filter_dat.sv
// Directed bench for fir_filter_dat: reset, impulse, step, full scale,
// short ramp sequence and asynchronous reset in mid-stream.
module tb_fir_filter_dat;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  fir_filter_dat_if #(.DW(8), .OW(20)) bus ();

  fir_filter_dat #(.NTAPS(16), .DW(8), .CW(8), .OW(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [19:0] exp);
    checks++;
    assert (bus.output_sample === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, bus.output_sample, exp);
    end
  endtask

  // Hold input constant and check the cumulative-sum response from zero.
  task automatic step_check(input string tag, input logic [7:0] v);
    int cum [16] = '{1,4,11,24,44,71,103,138,173,205,232,252,265,272,275,276};
    bus.input_sample = v;
    tick();
    chk({tag, "_e1"}, 20'd0);
    for (int m = 0; m < 16; m++) begin
      tick();
      chk($sformatf("%s_e%0d", tag, m + 2), 20'(int'(v) * cum[m]));
    end
    tick();
    chk({tag, "_steady"}, 20'(int'(v) * 276));
  endtask

  initial begin
    int imp [16] = '{1,3,7,13,20,27,32,35,35,32,27,20,13,7,3,1};

    // Reset held with a nonzero input: output stays 0
    rst_n = 1'b1;
    bus.input_sample = 8'd12;
    #2 rst_n = 1'b0;
    #1 chk("reset_async", 20'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("reset_hold%0d", i), 20'd0);
    end
    rst_n = 1'b1;

    // Impulse response
    bus.input_sample = 8'd1;
    tick();
    chk("imp_capture", 20'd0);
    bus.input_sample = 8'd0;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("imp_c%0d", k), 20'(imp[k]));
    end
    tick();
    chk("imp_tail", 20'd0);

    // Step of 5 from an all-zero history (impulse has fully drained)
    step_check("step5", 8'd5);

    // Full scale: no wrap at 255*276
    bus.input_sample = 8'd255;
    for (int i = 0; i < 17; i++) tick();
    chk("full_scale", 20'd70380);
    tick();
    chk("full_scale_hold", 20'd70380);

    // Reset, then sequence 5,10,12,15 held
    #1 rst_n = 1'b0;
    #1 chk("seq_reset", 20'd0);
    tick();
    rst_n = 1'b1;
    bus.input_sample = 8'd5;
    tick();
    chk("seq_e1", 20'd0);
    bus.input_sample = 8'd10;
    tick();
    chk("seq_e2", 20'd5);
    bus.input_sample = 8'd12;
    tick();
    chk("seq_e3", 20'd25);
    bus.input_sample = 8'd15;
    tick();
    chk("seq_e4", 20'd77);
    tick();
    chk("seq_e5", 20'd186);
    for (int i = 0; i < 16; i++) tick();
    chk("seq_steady", 20'd4140);

    // Mid-stream reset while the step response is in flight
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.input_sample = 8'd5;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_pre", 20'd220);
    #3 rst_n = 1'b0;
    #1 chk("mid_async_clear", 20'd0);
    bus.input_sample = 8'd12;
    tick();
    chk("mid_hold", 20'd0);
    rst_n = 1'b1;
    step_check("mid_step5", 8'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
